// File: rtl/irq_encoder_8_to_3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_enc_pkg
// Description : Shared sizes, FSM state type and one-hot helper for the
//               8-to-3 interrupt request encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot mask selecting the request bit named by a code.
    function automatic logic [N_REQ-1:0] onehot8(input logic [CODE_W-1:0] code);
        onehot8 = {{(N_REQ-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage : irq_enc_pkg
`default_nettype wire

// File: rtl/irq_encoder_8_to_3_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_encoder_8_to_3_if
// Description : Request/handshake bundle of the 8-to-3 interrupt encoder.
//               master = request source and code consumer, slave = encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_encoder_8_to_3_if;
    import irq_enc_pkg::*;

    logic              E;
    logic [N_REQ-1:0]  req;
    logic              ack;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [N_REQ-1:0]  pending;
    logic              coalesced;

    modport master (
        output E, req, ack,
        input  code, valid, pending, coalesced
    );

    modport slave (
        input  E, req, ack,
        output code, valid, pending, coalesced
    );

endinterface : irq_encoder_8_to_3_if
`default_nettype wire

// File: rtl/irq_encoder_8_to_3_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_8_3
// Description : Combinational 8-to-3 priority encoder, highest index wins.
//               any_o flags that at least one input is set.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_8_3
    import irq_enc_pkg::*;
(
    input  wire logic [N_REQ-1:0]  in_i,
    output      logic [CODE_W-1:0] code_o,
    output      logic              any_o
);

    // Ascending scan so the last (highest) set index overwrites lower ones.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_i[i]) begin
                code_o = CODE_W'(i);
            end
        end
        any_o = |in_i;
    end

endmodule : prio_enc_8_3
`default_nettype wire

// File: rtl/irq_encoder_8_to_3.sv
`default_nettype none
// ============================================================================
// Module      : irq_encoder_8_to_3
// Description : Latches eight request lines into a pending register and
//               presents the highest pending index as code/valid, held until
//               acked, then clears that bit. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_encoder_8_to_3
    import irq_enc_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    irq_encoder_8_to_3_if.slave    bus
);

    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              coal_q, coal_d;
    state_t            state_q, state_d;

    logic [N_REQ-1:0]  w_set;
    logic [N_REQ-1:0]  w_clr;
    logic [CODE_W-1:0] w_enc_code;
    logic              w_enc_any;

    // Encoder looks only at the registered pending set, so the FSM decides
    // one cycle after capture and nothing combinational reaches the outputs.
    prio_enc_8_3 u_prio_enc (
        .in_i   (pending_q),
        .code_o (w_enc_code),
        .any_o  (w_enc_any)
    );

    // Pending capture/clear; a new request on the acked bit keeps it pending.
    always_comb begin
        w_set     = bus.req & {N_REQ{bus.E}};
        w_clr     = (valid_q && bus.ack) ? onehot8(code_q) : '0;
        pending_d = (pending_q & ~w_clr) | w_set;
        coal_d    = coal_q | (|(w_set & pending_q & ~w_clr));
    end

    // Present/ack FSM; no preemption while a code is being presented.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (w_enc_any) begin
                    code_d  = w_enc_code;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            PRESENT: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            coal_q    <= 1'b0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            coal_q    <= coal_d;
            state_q   <= state_d;
        end
    end

    assign bus.code      = code_q;
    assign bus.valid     = valid_q;
    assign bus.pending   = pending_q;
    assign bus.coalesced = coal_q;

endmodule : irq_encoder_8_to_3
`default_nettype wire

// File: tb/tb_irq_encoder_8_to_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_encoder_8_to_3
// Description : Directed self-checking bench for irq_encoder_8_to_3 with a
//               cycle-level reference model compared on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_encoder_8_to_3;

    logic clk;
    logic rst_n;

    irq_encoder_8_to_3_if bus_if ();

    irq_encoder_8_to_3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_pend;
    logic [2:0] m_code;
    logic       m_valid;
    logic       m_coal;
    logic       m_ok = 1'b0;

    function automatic logic [2:0] highest(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
                break;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advance on each rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        logic [7:0] set_v, clr_v;
        if (!rst_n) begin
            m_pend  = 8'h00;
            m_code  = 3'd0;
            m_valid = 1'b0;
            m_coal  = 1'b0;
            m_ok    = 1'b1;
        end else begin
            set_v = bus_if.E ? bus_if.req : 8'h00;
            clr_v = (m_valid && bus_if.ack) ? (8'h01 << m_code) : 8'h00;
            if ((set_v & m_pend & ~clr_v) != 8'h00) m_coal = 1'b1;
            if (m_valid) begin
                if (bus_if.ack) m_valid = 1'b0;
            end else if (m_pend != 8'h00) begin
                m_valid = 1'b1;
                m_code  = highest(m_pend);
            end
            m_pend = (m_pend & ~clr_v) | set_v;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_pending",   int'(bus_if.pending),   int'(m_pend));
            chk("model_valid",     int'(bus_if.valid),     int'(m_valid));
            chk("model_code",      int'(bus_if.code),      int'(m_code));
            chk("model_coalesced", int'(bus_if.coalesced), int'(m_coal));
        end
    end

    // Drive one cycle of inputs and wait to the next falling edge.
    task automatic cyc(input logic [7:0] r, input logic e, input logic a);
        bus_if.req = r;
        bus_if.E   = e;
        bus_if.ack = a;
        @(negedge clk);
    endtask

    // Wait (bounded) for valid, check the code, then ack it for one cycle.
    task automatic present_ack(input int exp_code);
        int n;
        n = 0;
        while (!bus_if.valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("drain_valid", int'(bus_if.valid), 1);
        chk("drain_code", int'(bus_if.code), exp_code);
        cyc(8'h00, 1'b1, 1'b1);
        bus_if.ack = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus_if.req = 8'hFF;
        bus_if.E   = 1'b1;
        bus_if.ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pending", int'(bus_if.pending), 0);
        chk("rst_valid", int'(bus_if.valid), 0);
        chk("rst_code", int'(bus_if.code), 0);
        chk("rst_coal", int'(bus_if.coalesced), 0);

        // Release reset with all requests up for one cycle.
        rst_n = 1'b1;
        cyc(8'hFF, 1'b1, 1'b0);
        chk("post_rst_pending", int'(bus_if.pending), 8'hFF);
        chk("post_rst_valid0", int'(bus_if.valid), 0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("post_rst_valid1", int'(bus_if.valid), 1);
        chk("post_rst_code7", int'(bus_if.code), 7);
        for (int i = 7; i >= 0; i--) present_ack(i);
        chk("drain_pending", int'(bus_if.pending), 0);
        cyc(8'h00, 1'b1, 1'b0);

        // Single pulse on bit 2, ack three cycles later.
        cyc(8'h04, 1'b1, 1'b0);
        chk("p2_pending", int'(bus_if.pending), 8'h04);
        cyc(8'h00, 1'b1, 1'b0);
        chk("p2_valid", int'(bus_if.valid), 1);
        chk("p2_code", int'(bus_if.code), 2);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("p2_held", int'(bus_if.code), 2);
        cyc(8'h00, 1'b1, 1'b1);
        chk("p2_after_ack_valid", int'(bus_if.valid), 0);
        chk("p2_after_ack_pend", int'(bus_if.pending), 0);
        cyc(8'h00, 1'b1, 1'b0);

        // 0x81 with ack held high: codes 7 then 0, valid 1,0,1,0.
        cyc(8'h81, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("b2b_v1", int'(bus_if.valid), 1);
        chk("b2b_c7", int'(bus_if.code), 7);
        cyc(8'h00, 1'b1, 1'b1);
        chk("b2b_v0a", int'(bus_if.valid), 0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("b2b_v1b", int'(bus_if.valid), 1);
        chk("b2b_c0", int'(bus_if.code), 0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("b2b_v0b", int'(bus_if.valid), 0);
        chk("b2b_pend", int'(bus_if.pending), 0);
        cyc(8'h00, 1'b1, 1'b0);

        // No preemption: code 1 stays while bit 6 arrives.
        cyc(8'h02, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("np_code1", int'(bus_if.code), 1);
        cyc(8'h40, 1'b1, 1'b0);
        chk("np_hold", int'(bus_if.code), 1);
        chk("np_pend", int'(bus_if.pending), 8'h42);
        cyc(8'h00, 1'b1, 1'b1);
        chk("np_gap", int'(bus_if.valid), 0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("np_code6", int'(bus_if.code), 6);
        chk("np_valid6", int'(bus_if.valid), 1);
        cyc(8'h00, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b0);

        // Enable low blocks capture.
        cyc(8'h10, 1'b0, 1'b0);
        cyc(8'h10, 1'b0, 1'b1);
        chk("en_pend", int'(bus_if.pending), 0);
        chk("en_valid", int'(bus_if.valid), 0);
        cyc(8'h10, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("en_code4", int'(bus_if.code), 4);
        chk("en_valid4", int'(bus_if.valid), 1);
        cyc(8'h00, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b0);

        // Set wins over clear on bit 3; repeat request flags coalesced.
        cyc(8'h08, 1'b1, 1'b0);
        cyc(8'h08, 1'b1, 1'b0);
        chk("sw_code3", int'(bus_if.code), 3);
        chk("sw_coal", int'(bus_if.coalesced), 1);
        cyc(8'h08, 1'b1, 1'b1);
        chk("sw_pend", int'(bus_if.pending), 8'h08);
        chk("sw_gap", int'(bus_if.valid), 0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("sw_again", int'(bus_if.code), 3);
        chk("sw_again_v", int'(bus_if.valid), 1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("sw_cleared", int'(bus_if.pending), 0);
        chk("sw_coal_sticky", int'(bus_if.coalesced), 1);

        // Reset in the middle of a handshake drops everything.
        cyc(8'h20, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("mr_code5", int'(bus_if.code), 5);
        rst_n = 1'b0;
        cyc(8'h00, 1'b1, 1'b1);
        chk("mr_valid", int'(bus_if.valid), 0);
        chk("mr_code", int'(bus_if.code), 0);
        chk("mr_coal", int'(bus_if.coalesced), 0);
        rst_n = 1'b1;
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("mr_idle", int'(bus_if.valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_irq_encoder_8_to_3
`default_nettype wire
